// File: rtl/out_display.sv
// Binary-to-BCD converter (double dabble) driving a multiplexed common-anode 7-segment display.
// Optional leading-zero blanking is enabled by defining OUT_DISPLAY_LZB_EN.
module out_display #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 1024
) (
  input  logic                  mclk,
  input  logic                  i_reset,
  input  logic [WIDTH-1:0]      i_data,
  output logic                  o_busy,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic [6:0]            o_seg,
  output logic [DIGITS-1:0]     o_an
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   last;
  logic [WIDTH-1:0]   shift;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   adjusted;
  logic [BIT_W-1:0]   bit_cnt;

  logic [CNT_W-1:0]   refresh_cnt;
  logic [IDX_W-1:0]   digit_idx;
  logic [IDX_W-1:0]   lit_idx;
  logic               lit;
  logic               wrap;
  logic [IDX_W-1:0]   sel;
  logic [3:0]         nibble;
  logic [6:0]         seg_next;

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    case (n)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  // Add-3 correction applied to every BCD nibble before each shift.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    adjusted = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge mclk or posedge i_reset) begin
    if (i_reset) begin
      state   <= IDLE;
      last    <= '0;
      shift   <= '0;
      scratch <= '0;
      bit_cnt <= '0;
      o_busy  <= 1'b0;
      o_bcd   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_data != last) begin
            last    <= i_data;
            shift   <= i_data;
            scratch <= '0;
            bit_cnt <= '0;
            o_busy  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          {scratch, shift} <= {adjusted, shift} << 1;
          bit_cnt          <= bit_cnt + BIT_W'(1);
          if (bit_cnt == BIT_W'(WIDTH - 1))
            state <= DONE;
        end
        DONE: begin
          o_bcd  <= scratch;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wrap = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));

  // On a wrap the incoming digit is shown on the same edge as its anode; otherwise
  // the lit digit keeps tracking o_bcd so a new result appears one edge later.
  assign sel = wrap ? digit_idx : lit_idx;

  always_comb begin
    nibble = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == sel)
        nibble = o_bcd[4*i +: 4];
    end
  end

`ifdef OUT_DISPLAY_LZB_EN
  logic upper_nz;

  always_comb begin
    upper_nz = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) >= sel && o_bcd[4*i +: 4] != 4'd0)
        upper_nz = 1'b1;
    end
    seg_next = (sel != '0 && !upper_nz) ? SEG_BLANK : seg_code(nibble);
  end
`else
  assign seg_next = seg_code(nibble);
`endif

  always_ff @(posedge mclk or posedge i_reset) begin
    if (i_reset) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
      lit_idx     <= '0;
      lit         <= 1'b0;
      o_an        <= '1;
      o_seg       <= SEG_BLANK;
    end else begin
      if (wrap) begin
        refresh_cnt <= '0;
        lit_idx     <= digit_idx;
        lit         <= 1'b1;
        o_an        <= ~(DIGITS'(1) << digit_idx);
        digit_idx   <= (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
      end else begin
        refresh_cnt <= refresh_cnt + CNT_W'(1);
      end
      o_seg <= (wrap || lit) ? seg_next : SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_out_display.sv
// Directed self-checking bench for out_display (WIDTH=8, DIGITS=3, REFRESH_DIV=4).
module tb_out_display;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int RDIV   = 4;

`ifdef OUT_DISPLAY_LZB_EN
  localparam logic [6:0] LEAD0 = 7'h7F;
`else
  localparam logic [6:0] LEAD0 = 7'h40;
`endif

  logic             mclk = 1'b0;
  logic             i_reset;
  logic [WIDTH-1:0] i_data;
  logic             o_busy;
  logic [11:0]      o_bcd;
  logic [6:0]       o_seg;
  logic [2:0]       o_an;

  int total  = 0;
  int passed = 0;

  always #5 mclk = ~mclk;

  out_display #(.WIDTH(WIDTH), .DIGITS(DIGITS), .REFRESH_DIV(RDIV)) dut (
    .mclk    (mclk),
    .i_reset (i_reset),
    .i_data  (i_data),
    .o_busy  (o_busy),
    .o_bcd   (o_bcd),
    .o_seg   (o_seg),
    .o_an    (o_an)
  );

  typedef struct {
    logic [7:0]  data;
    logic [11:0] bcd;
  } conv_vec_t;

  conv_vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      passed++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge mclk);
  endtask

  // Expected segment pattern for digit idx of a BCD value, from the segment table.
  function automatic logic [6:0] exp_seg(input logic [11:0] bcd, input int idx);
    logic [6:0] tbl [10];
    logic [3:0] n;
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    n = bcd[4*idx +: 4];
`ifdef OUT_DISPLAY_LZB_EN
    if (idx == 2 && bcd[11:8] == 4'd0) return 7'h7F;
    if (idx == 1 && bcd[11:4] == 8'd0) return 7'h7F;
`endif
    return (n > 4'd9) ? 7'h7F : tbl[n];
  endfunction

  // Apply a value from a negedge; leaves the bench one cycle after o_bcd updates.
  task automatic convert(input logic [7:0] d, input logic [11:0] exp, input logic [11:0] old,
                         input string tag);
    i_data = d;
    tick(1);
    check({tag, "_busy_e0"}, o_busy, 1'b1);
    tick(8);
    check({tag, "_busy_e8"}, o_busy, 1'b1);
    check({tag, "_bcd_held_e8"}, o_bcd, old);
    tick(1);
    check({tag, "_busy_e9"}, o_busy, 1'b0);
    check({tag, "_bcd_e9"}, o_bcd, exp);
    tick(1);
  endtask

  task automatic show(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                      input string tag);
    int n = 0;
    while (o_an !== 3'b110 && n < 16) begin
      tick(1);
      n++;
    end
    check({tag, "_an0_found"}, o_an, 3'b110);
    check({tag, "_seg0"}, o_seg, s0);
    tick(RDIV);
    check({tag, "_an1"}, o_an, 3'b101);
    check({tag, "_seg1"}, o_seg, s1);
    tick(RDIV);
    check({tag, "_an2"}, o_an, 3'b011);
    check({tag, "_seg2"}, o_seg, s2);
    tick(RDIV);
    check({tag, "_an0_again"}, o_an, 3'b110);
    check({tag, "_seg0_again"}, o_seg, s0);
  endtask

  initial begin
    int bad;
    int idx;
    logic [11:0] old;

    vecs[0] = '{8'd255, 12'h255};
    vecs[1] = '{8'd1,   12'h001};
    vecs[2] = '{8'd9,   12'h009};
    vecs[3] = '{8'd10,  12'h010};
    vecs[4] = '{8'd99,  12'h099};
    vecs[5] = '{8'd128, 12'h128};
    vecs[6] = '{8'd200, 12'h200};
    vecs[7] = '{8'd64,  12'h064};
    vecs[8] = '{8'd0,   12'h000};
    vecs[9] = '{8'd250, 12'h250};

    i_reset = 1'b1;
    i_data  = '0;
    tick(2);
    check("rst_busy", o_busy, 1'b0);
    check("rst_bcd",  o_bcd,  12'h000);
    check("rst_an",   o_an,   3'b111);
    check("rst_seg",  o_seg,  7'h7F);

    i_reset = 1'b0;
    tick(RDIV - 1);
    check("first_light_pre_an", o_an, 3'b111);
    tick(1);
    check("first_light_an",  o_an,  3'b110);
    check("first_light_seg", o_seg, 7'h40);

    bad = 0;
    for (int k = 0; k < 46; k++) begin
      tick(1);
      if (o_busy !== 1'b0 || o_bcd !== 12'h000) bad++;
    end
    check("idle_no_conversion", bad, 0);

    old = 12'h000;
    for (int i = 0; i < 10; i++) begin
      convert(vecs[i].data, vecs[i].bcd, old, $sformatf("vec%0d", i));
      old = vecs[i].bcd;
    end

    // Value changes mid-conversion: 100 completes, then 42 follows.
    i_data = 8'd100;
    tick(1);
    check("chg_busy_e0", o_busy, 1'b1);
    tick(2);
    i_data = 8'd42;
    tick(6);
    check("chg_bcd_e8", o_bcd, 12'h250);
    tick(1);
    check("chg_bcd_e9",  o_bcd,  12'h100);
    check("chg_busy_e9", o_busy, 1'b0);
    tick(1);
    check("chg_busy_e10", o_busy, 1'b1);
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      if (o_bcd !== 12'h100) bad++;
    end
    check("chg_no_garbage", bad, 0);
    tick(1);
    check("chg_bcd_e19",  o_bcd,  12'h042);
    check("chg_busy_e19", o_busy, 1'b0);
    tick(1);

    // Lit digit follows a new o_bcd one edge after the update.
    convert(8'd137, 12'h137, 12'h042, "upd");
    idx = (o_an == 3'b110) ? 0 : (o_an == 3'b101) ? 1 : 2;
    check("upd_seg_follows", o_seg, exp_seg(12'h137, idx));
    show(7'h78, 7'h30, 7'h79, "disp137");

    // Asynchronous reset in the middle of a conversion.
    i_data = 8'd200;
    tick(1);
    check("rstmid_busy_e0", o_busy, 1'b1);
    tick(3);
    #2 i_reset = 1'b1;
    #1;
    check("rstmid_busy", o_busy, 1'b0);
    check("rstmid_bcd",  o_bcd,  12'h000);
    check("rstmid_an",   o_an,   3'b111);
    check("rstmid_seg",  o_seg,  7'h7F);
    @(negedge mclk);
    i_reset = 1'b0;
    tick(1);
    check("rstmid_recapture", o_busy, 1'b1);
    tick(8);
    check("rstmid_busy_e8", o_busy, 1'b1);
    tick(1);
    check("rstmid_bcd_e9",  o_bcd,  12'h200);
    check("rstmid_busy_e9", o_busy, 1'b0);
    tick(1);

    convert(8'd7, 12'h007, 12'h200, "seven");
    show(7'h78, LEAD0, LEAD0, "disp7");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
